gerador_rodadas: RTL

GERADOR_RODADAS -- requirements
Module: gerador_rodadas

---
 rtl/gerador_rodadas.sv | 139 +++++++++++++
 1 files changed

// File: rtl/gerador_rodadas.sv
// gerador_rodadas: sequences the rounds of a game, showing a target value to
// the grader, waiting (with timeout) for a sensor sample, latching the score
// of each round and keeping the running total.
module gerador_rodadas #(
    parameter int N_RODADAS = 5,    // rounds per game, 1..6
    parameter int ESPERA    = 1000  // wait cycles before a round times out, 2..65535
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       sensor_valido,
    input  logic [3:0] nota,
    output logic [3:0] ideal,
    output logic       enable,
    output logic [2:0] rodada,
    output logic [3:0] nota_registrada,
    output logic [5:0] total,
    output logic       ocupado,
    output logic       pronto,
    output logic       expirou
);

    typedef enum logic [2:0] {
        OCIOSO,
        APRESENTA,
        AGUARDA,
        CAPTURA,
        FIM
    } estado_t;

    localparam logic [2:0]  ULTIMA = 3'(N_RODADAS - 1);
    localparam logic [15:0] LIMITE = 16'(ESPERA - 1);

    estado_t     state_q, state_d;
    logic [2:0]  rodada_q, rodada_d;
    logic [3:0]  nota_reg_q, nota_reg_d;
    logic [5:0]  total_q, total_d;
    logic        expirou_q, expirou_d;
    logic        timeout_q, timeout_d;
    logic [15:0] cont_q, cont_d;
    logic [3:0]  valor;

    // State and datapath registers; everything clears on reset, mid-round included.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= OCIOSO;
            rodada_q   <= 3'd0;
            nota_reg_q <= 4'd0;
            total_q    <= 6'd0;
            expirou_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cont_q     <= 16'd0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q    <= state_d;
            rodada_q   <= rodada_d;
            nota_reg_q <= nota_reg_d;
            total_q    <= total_d;
            expirou_q  <= expirou_d;
            timeout_q  <= timeout_d;
            cont_q     <= cont_d;
        end
    end

    // Next-state and next-datapath logic for the round sequencer.
    always_comb begin
        // NOTE: hold-by-default assignments first, so no path through the case infers a latch.
        state_d    = state_q;
        rodada_d   = rodada_q;
        nota_reg_d = nota_reg_q;
        total_d    = total_q;
        expirou_d  = expirou_q;
        timeout_d  = timeout_q;
        cont_d     = cont_q;
        // A timed-out round or an out-of-range grade scores nothing.
        valor      = (timeout_q || (nota > 4'd10)) ? 4'd0 : nota;

        unique case (state_q)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    state_d    = APRESENTA;
                    rodada_d   = 3'd0;
                    total_d    = 6'd0;
                    nota_reg_d = 4'd0;
                    expirou_d  = 1'b0;
                end
            end
            APRESENTA: begin
                cont_d  = 16'd0;
                state_d = AGUARDA;
            end
            AGUARDA: begin
                // A sample arriving on the last wait cycle still counts.
                if (sensor_valido) begin
                    timeout_d = 1'b0;
                    state_d   = CAPTURA;
                end else if (cont_q == LIMITE) begin
                    timeout_d = 1'b1;
                    state_d   = CAPTURA;
                end else begin
                    cont_d = cont_q + 16'd1;
                end
            end
            CAPTURA: begin
                nota_reg_d = valor;
                total_d    = total_q + {2'b00, valor};
                expirou_d  = timeout_q;
                if (rodada_q == ULTIMA) begin
                    state_d = FIM;
                end else begin
                    rodada_d = rodada_q + 3'd1;
                    state_d  = APRESENTA;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    // Outputs decoded only from state and registers, never from inputs.
    always_comb begin
        enable          = (state_q == CAPTURA);
        ocupado         = (state_q == APRESENTA) || (state_q == AGUARDA) || (state_q == CAPTURA);
        pronto          = (state_q == FIM);
        rodada          = rodada_q;
        nota_registrada = nota_reg_q;
        total           = total_q;
        expirou         = expirou_q;
        unique case (rodada_q)
            3'd0:    ideal = 4'd3;
            3'd1:    ideal = 4'd7;
            3'd2:    ideal = 4'd1;
            3'd3:    ideal = 4'd9;
            3'd4:    ideal = 4'd5;
            3'd5:    ideal = 4'd2;
            default: ideal = 4'd0;
        endcase
    end

endmodule
